// File: rtl/bp_me_dma_arbiter.sv
// Round-robin arbiter sharing one DMA channel among several bsg_cache DMA ports.
// Writes lock the channel for a full burst; read fills are steered back in issue order.
module bp_me_dma_arbiter #(
  parameter int unsigned num_dma_p         = 2,
  parameter int unsigned addr_width_p      = 28,
  parameter int unsigned data_width_p      = 64,
  parameter int unsigned beats_per_block_p = 8,
  parameter int unsigned max_outstanding_p = 4,
  localparam int unsigned dma_pkt_width_lp = addr_width_p + 1,
  localparam int unsigned lg_num_dma_lp    = (num_dma_p > 1) ? $clog2(num_dma_p) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,

  input  logic [num_dma_p*dma_pkt_width_lp-1:0] cache_dma_pkt_i,
  input  logic [num_dma_p-1:0]                  cache_dma_pkt_v_i,
  output logic [num_dma_p-1:0]                  cache_dma_pkt_yumi_o,

  output logic [num_dma_p*data_width_p-1:0]     cache_dma_data_o,
  output logic [num_dma_p-1:0]                  cache_dma_data_v_o,
  input  logic [num_dma_p-1:0]                  cache_dma_data_ready_and_i,

  input  logic [num_dma_p*data_width_p-1:0]     cache_dma_data_i,
  input  logic [num_dma_p-1:0]                  cache_dma_data_v_i,
  output logic [num_dma_p-1:0]                  cache_dma_data_yumi_o,

  output logic [dma_pkt_width_lp-1:0]           dma_pkt_o,
  output logic                                  dma_pkt_v_o,
  input  logic                                  dma_pkt_yumi_i,

  input  logic [data_width_p-1:0]               dma_data_i,
  input  logic                                  dma_data_v_i,
  output logic                                  dma_data_ready_and_o,

  output logic [data_width_p-1:0]               dma_data_o,
  output logic                                  dma_data_v_o,
  input  logic                                  dma_data_yumi_i
);

  localparam int unsigned cnt_width_lp  = (beats_per_block_p > 1) ? $clog2(beats_per_block_p) : 1;
  localparam int unsigned ptr_width_lp  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int unsigned fcnt_width_lp = $clog2(max_outstanding_p + 1);
  localparam logic [cnt_width_lp-1:0] last_beat_lp = cnt_width_lp'(beats_per_block_p - 1);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp  = ptr_width_lp'(max_outstanding_p - 1);

  typedef enum logic [0:0] {e_ready, e_write} state_e;

  state_e state_q, state_d;

  logic [lg_num_dma_lp-1:0]    last_grant_q, wr_id_q, grant;
  logic [cnt_width_lp-1:0]     wr_cnt_q, rd_cnt_q;
  logic [lg_num_dma_lp-1:0]    fifo_mem [max_outstanding_p];
  logic [ptr_width_lp-1:0]     wptr_q, rptr_q;
  logic [fcnt_width_lp-1:0]    fifo_cnt_q;
  logic [lg_num_dma_lp-1:0]    head;
  logic [dma_pkt_width_lp-1:0] pkt   [num_dma_p];
  logic [data_width_p-1:0]     wdata [num_dma_p];

  logic fifo_full, fifo_empty, pkt_v, pkt_fire, pkt_write, wr_fire, rd_ready, rd_fire;
  logic push, pop;

  always_comb begin
    for (int i = 0; i < int'(num_dma_p); i++) begin
      pkt[i]   = cache_dma_pkt_i[i*dma_pkt_width_lp +: dma_pkt_width_lp];
      wdata[i] = cache_dma_data_i[i*data_width_p +: data_width_p];
    end
  end

  // Lowest valid index above last_grant wins; otherwise wrap to lowest valid index.
  always_comb begin
    logic                     hi_found;
    logic [lg_num_dma_lp-1:0] hi_idx, lo_idx;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = int'(num_dma_p) - 1; i >= 0; i--) begin
      if (cache_dma_pkt_v_i[i]) begin
        if (i > int'(last_grant_q)) begin
          hi_found = 1'b1;
          hi_idx   = lg_num_dma_lp'(i);
        end else begin
          lo_idx   = lg_num_dma_lp'(i);
        end
      end
    end
    grant = hi_found ? hi_idx : lo_idx;
  end

  assign fifo_full  = (fifo_cnt_q == fcnt_width_lp'(max_outstanding_p));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign head       = fifo_mem[rptr_q];
  assign pkt_write  = pkt[grant][dma_pkt_width_lp-1];

  assign pkt_v    = ~reset_i & (|cache_dma_pkt_v_i) & ~fifo_full & (state_q == e_ready);
  assign pkt_fire = pkt_v & dma_pkt_yumi_i;
  assign wr_fire  = ~reset_i & (state_q == e_write) & dma_data_yumi_i;
  assign rd_ready = ~reset_i & ~fifo_empty & cache_dma_data_ready_and_i[head];
  assign rd_fire  = dma_data_v_i & rd_ready;
  assign push     = pkt_fire & ~pkt_write;
  assign pop      = rd_fire & (rd_cnt_q == last_beat_lp);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= e_ready;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_ready: if (pkt_fire && pkt_write) state_d = e_write;
      e_write: if (wr_fire && (wr_cnt_q == last_beat_lp)) state_d = e_ready;
      default: state_d = e_ready;
    endcase
  end

  always_comb begin
    dma_pkt_o             = pkt[grant];
    dma_pkt_v_o           = pkt_v;
    cache_dma_pkt_yumi_o  = '0;
    if (pkt_v) cache_dma_pkt_yumi_o[grant] = dma_pkt_yumi_i;

    dma_data_o            = wdata[wr_id_q];
    dma_data_v_o          = 1'b0;
    cache_dma_data_yumi_o = '0;
    if (!reset_i && (state_q == e_write)) begin
      dma_data_v_o                   = cache_dma_data_v_i[wr_id_q];
      cache_dma_data_yumi_o[wr_id_q] = dma_data_yumi_i;
    end

    cache_dma_data_o     = {num_dma_p{dma_data_i}};
    cache_dma_data_v_o   = '0;
    if (!reset_i && !fifo_empty) cache_dma_data_v_o[head] = dma_data_v_i;
    dma_data_ready_and_o = rd_ready;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_grant_q <= lg_num_dma_lp'(num_dma_p - 1);
      wr_id_q      <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      if (pkt_fire) last_grant_q <= grant;
      if (pkt_fire && pkt_write) begin
        wr_id_q  <= grant;
        wr_cnt_q <= '0;
      end else if (wr_fire) begin
        wr_cnt_q <= (wr_cnt_q == last_beat_lp) ? '0 : wr_cnt_q + 1'b1;
      end
      if (rd_fire) rd_cnt_q <= (rd_cnt_q == last_beat_lp) ? '0 : rd_cnt_q + 1'b1;
      if (push) wptr_q <= (wptr_q == last_ptr_lp) ? '0 : wptr_q + 1'b1;
      if (pop)  rptr_q <= (rptr_q == last_ptr_lp) ? '0 : rptr_q + 1'b1;
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr_q] <= grant;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(dma_data_v_i && fifo_empty))
        else $error("dma_data_v_i with no outstanding read");
      assert (!(dma_pkt_yumi_i && !dma_pkt_v_o))
        else $error("dma_pkt_yumi_i without dma_pkt_v_o");
      assert (!(dma_data_yumi_i && !dma_data_v_o))
        else $error("dma_data_yumi_i without dma_data_v_o");
    end
  end
`endif

endmodule

// File: tb/tb_bp_me_dma_arbiter.sv
// Directed bench for bp_me_dma_arbiter: reset, reads, round-robin, write lock,
// FIFO full, backpressure and reset during a write burst.
module tb_bp_me_dma_arbiter;

  localparam int N = 2;
  localparam int W = 29;
  localparam int D = 64;

  logic             clk = 1'b0;
  logic             reset_i;
  logic [N*W-1:0]   cache_dma_pkt_i;
  logic [N-1:0]     cache_dma_pkt_v_i;
  logic [N-1:0]     cache_dma_pkt_yumi_o;
  logic [N*D-1:0]   cache_dma_data_o;
  logic [N-1:0]     cache_dma_data_v_o;
  logic [N-1:0]     cache_dma_data_ready_and_i;
  logic [N*D-1:0]   cache_dma_data_i;
  logic [N-1:0]     cache_dma_data_v_i;
  logic [N-1:0]     cache_dma_data_yumi_o;
  logic [W-1:0]     dma_pkt_o;
  logic             dma_pkt_v_o;
  logic             dma_pkt_yumi_i;
  logic [D-1:0]     dma_data_i;
  logic             dma_data_v_i;
  logic             dma_data_ready_and_o;
  logic [D-1:0]     dma_data_o;
  logic             dma_data_v_o;
  logic             dma_data_yumi_i;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bp_me_dma_arbiter dut (
    .clk_i                      (clk),
    .reset_i                    (reset_i),
    .cache_dma_pkt_i            (cache_dma_pkt_i),
    .cache_dma_pkt_v_i          (cache_dma_pkt_v_i),
    .cache_dma_pkt_yumi_o       (cache_dma_pkt_yumi_o),
    .cache_dma_data_o           (cache_dma_data_o),
    .cache_dma_data_v_o         (cache_dma_data_v_o),
    .cache_dma_data_ready_and_i (cache_dma_data_ready_and_i),
    .cache_dma_data_i           (cache_dma_data_i),
    .cache_dma_data_v_i         (cache_dma_data_v_i),
    .cache_dma_data_yumi_o      (cache_dma_data_yumi_o),
    .dma_pkt_o                  (dma_pkt_o),
    .dma_pkt_v_o                (dma_pkt_v_o),
    .dma_pkt_yumi_i             (dma_pkt_yumi_i),
    .dma_data_i                 (dma_data_i),
    .dma_data_v_i               (dma_data_v_i),
    .dma_data_ready_and_o       (dma_data_ready_and_o),
    .dma_data_o                 (dma_data_o),
    .dma_data_v_o               (dma_data_v_o),
    .dma_data_yumi_i            (dma_data_yumi_i)
  );

  task automatic clear_inputs();
    cache_dma_pkt_i            = '0;
    cache_dma_pkt_v_i          = '0;
    cache_dma_data_ready_and_i = '0;
    cache_dma_data_i           = '0;
    cache_dma_data_v_i         = '0;
    dma_pkt_yumi_i             = 1'b0;
    dma_data_i                 = '0;
    dma_data_v_i               = 1'b0;
    dma_data_yumi_i            = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i                    = 1'b1;
    cache_dma_pkt_i            = {1'b0, 28'h0AA, 1'b0, 28'h055};
    cache_dma_pkt_v_i          = 2'b11;
    dma_pkt_yumi_i             = 1'b1;
    cache_dma_data_v_i         = 2'b11;
    cache_dma_data_ready_and_i = 2'b11;
    dma_data_v_i               = 1'b1;
    dma_data_yumi_i            = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (dma_pkt_v_o !== 1'b0) $display("FAIL reset_pkt_v: got %0b expected 0", dma_pkt_v_o);
    else passed++;
    total++;
    if (cache_dma_pkt_yumi_o !== 2'b00)
      $display("FAIL reset_pkt_yumi: got %b expected 00", cache_dma_pkt_yumi_o);
    else passed++;
    total++;
    if (dma_data_v_o !== 1'b0) $display("FAIL reset_data_v: got %0b expected 0", dma_data_v_o);
    else passed++;
    total++;
    if (dma_data_ready_and_o !== 1'b0)
      $display("FAIL reset_ready: got %0b expected 0", dma_data_ready_and_o);
    else passed++;
    total++;
    if (cache_dma_data_v_o !== 2'b00)
      $display("FAIL reset_cache_data_v: got %b expected 00", cache_dma_data_v_o);
    else passed++;
    total++;
    if (cache_dma_data_yumi_o !== 2'b00)
      $display("FAIL reset_data_yumi: got %b expected 00", cache_dma_data_yumi_o);
    else passed++;
    @(negedge clk);
    reset_i = 1'b0;
    clear_inputs();
    cache_dma_data_ready_and_i = 2'b11;
    #1;
    total++;
    if (dma_data_ready_and_o !== 1'b0)
      $display("FAIL reset_fifo_empty: got ready %0b expected 0", dma_data_ready_and_o);
    else passed++;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    cache_dma_pkt_i[W-1:0] = {1'b0, 28'h100};
    cache_dma_pkt_v_i      = 2'b01;
    #1;
    total++;
    if (dma_pkt_v_o !== 1'b1) $display("FAIL read_pkt_v: got %0b expected 1", dma_pkt_v_o);
    else passed++;
    total++;
    if (dma_pkt_o !== 29'h100) $display("FAIL read_pkt: got %h expected %h", dma_pkt_o, 29'h100);
    else passed++;
    dma_pkt_yumi_i = 1'b1;
    #1;
    total++;
    if (cache_dma_pkt_yumi_o !== 2'b01)
      $display("FAIL read_pkt_yumi: got %b expected 01", cache_dma_pkt_yumi_o);
    else passed++;
    @(negedge clk);
    cache_dma_pkt_v_i          = 2'b00;
    dma_pkt_yumi_i             = 1'b0;
    cache_dma_data_ready_and_i = 2'b11;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      dma_data_v_i = 1'b1;
      dma_data_i   = 64'h1000 + 64'(b);
      #1;
      total++;
      if (cache_dma_data_v_o !== 2'b01)
        $display("FAIL read_beat%0d_v: got %b expected 01", b, cache_dma_data_v_o);
      else passed++;
      if (b == 5) begin
        total++;
        if (cache_dma_data_o[2*D-1:D] !== 64'h1005)
          $display("FAIL read_lane1_data: got %h expected %h", cache_dma_data_o[2*D-1:D],
                   64'h1005);
        else passed++;
      end
    end
    @(negedge clk);
    dma_data_v_i = 1'b0;
    #1;
    total++;
    if (dma_data_ready_and_o !== 1'b0)
      $display("FAIL read_fifo_drained: got ready %0b expected 0", dma_data_ready_and_o);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_oh;
    do_reset();
    cache_dma_pkt_i   = {1'b0, 28'hB00, 1'b0, 28'hA00};
    cache_dma_pkt_v_i = 2'b11;
    dma_pkt_yumi_i    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      total++;
      if (cache_dma_pkt_yumi_o !== exp_oh)
        $display("FAIL rr_grant%0d: got %b expected %b", k, cache_dma_pkt_yumi_o, exp_oh);
      else passed++;
      total++;
      if (dma_pkt_o !== ((k % 2 == 0) ? 29'hA00 : 29'hB00))
        $display("FAIL rr_pkt%0d: got %h expected %h", k, dma_pkt_o,
                 (k % 2 == 0) ? 29'hA00 : 29'hB00);
      else passed++;
    end
    @(negedge clk);
    cache_dma_pkt_v_i          = 2'b00;
    dma_pkt_yumi_i             = 1'b0;
    cache_dma_data_ready_and_i = 2'b11;
    for (int blk = 0; blk < 4; blk++) begin
      exp_oh = (blk % 2 == 0) ? 2'b01 : 2'b10;
      for (int b = 0; b < 8; b++) begin
        @(negedge clk);
        dma_data_v_i = 1'b1;
        #1;
        total++;
        if (cache_dma_data_v_o !== exp_oh)
          $display("FAIL rr_return_blk%0d_beat%0d: got %b expected %b", blk, b,
                   cache_dma_data_v_o, exp_oh);
        else passed++;
      end
    end
    @(negedge clk);
    dma_data_v_i = 1'b0;
  endtask

  task automatic test_write_lock();
    do_reset();
    cache_dma_pkt_i   = {1'b1, 28'h200, 1'b0, 28'h300};
    cache_dma_pkt_v_i = 2'b10;
    dma_pkt_yumi_i    = 1'b1;
    #1;
    total++;
    if (cache_dma_pkt_yumi_o !== 2'b10)
      $display("FAIL wr_pkt_yumi: got %b expected 10", cache_dma_pkt_yumi_o);
    else passed++;
    @(negedge clk);
    dma_pkt_yumi_i     = 1'b0;
    cache_dma_pkt_v_i  = 2'b11;
    cache_dma_data_v_i = 2'b11;
    dma_data_yumi_i    = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (b > 0) @(negedge clk);
      cache_dma_data_i = {64'h2000 + 64'(b), 64'hDEAD_BEEF};
      #1;
      total++;
      if (dma_pkt_v_o !== 1'b0)
        $display("FAIL wr_lock_beat%0d: got pkt_v %0b expected 0", b, dma_pkt_v_o);
      else passed++;
      total++;
      if (dma_data_o !== 64'h2000 + 64'(b))
        $display("FAIL wr_data_beat%0d: got %h expected %h", b, dma_data_o, 64'h2000 + 64'(b));
      else passed++;
      total++;
      if (cache_dma_data_yumi_o !== 2'b10)
        $display("FAIL wr_yumi_beat%0d: got %b expected 10", b, cache_dma_data_yumi_o);
      else passed++;
    end
    @(negedge clk);
    dma_data_yumi_i    = 1'b0;
    cache_dma_data_v_i = 2'b00;
    cache_dma_pkt_v_i  = 2'b01;
    #1;
    total++;
    if (dma_pkt_v_o !== 1'b1) $display("FAIL wr_turnaround: got pkt_v %0b expected 1", dma_pkt_v_o);
    else passed++;
    total++;
    if (dma_pkt_o !== 29'h300) $display("FAIL wr_next_pkt: got %h expected %h", dma_pkt_o, 29'h300);
    else passed++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_fifo_full();
    do_reset();
    cache_dma_pkt_i   = {1'b0, 28'h0, 1'b0, 28'h400};
    cache_dma_pkt_v_i = 2'b01;
    dma_pkt_yumi_i    = 1'b1;
    for (int k = 0; k < 3; k++) @(negedge clk);
    @(negedge clk);
    dma_pkt_yumi_i = 1'b0;
    #1;
    total++;
    if (dma_pkt_v_o !== 1'b0) $display("FAIL full_block: got pkt_v %0b expected 0", dma_pkt_v_o);
    else passed++;
    cache_dma_data_ready_and_i = 2'b11;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      dma_data_v_i = 1'b1;
      #1;
      if (b == 7) begin
        total++;
        if (dma_pkt_v_o !== 1'b0)
          $display("FAIL full_pop_cycle: got pkt_v %0b expected 0", dma_pkt_v_o);
        else passed++;
      end
    end
    @(negedge clk);
    dma_data_v_i = 1'b0;
    #1;
    total++;
    if (dma_pkt_v_o !== 1'b1) $display("FAIL full_reassert: got pkt_v %0b expected 1", dma_pkt_v_o);
    else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    cache_dma_pkt_i   = {1'b0, 28'h0, 1'b0, 28'h480};
    cache_dma_pkt_v_i = 2'b01;
    dma_pkt_yumi_i    = 1'b1;
    @(negedge clk);
    cache_dma_pkt_v_i = 2'b00;
    dma_pkt_yumi_i    = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      dma_data_v_i               = 1'b1;
      cache_dma_data_ready_and_i = (c == 3 || c == 4) ? 2'b10 : 2'b11;
      #1;
      if (c == 3 || c == 4) begin
        total++;
        if (dma_data_ready_and_o !== 1'b0)
          $display("FAIL bp_stall%0d_ready: got %0b expected 0", c, dma_data_ready_and_o);
        else passed++;
        total++;
        if (cache_dma_data_v_o !== 2'b01)
          $display("FAIL bp_stall%0d_v: got %b expected 01", c, cache_dma_data_v_o);
        else passed++;
      end else begin
        total++;
        if (dma_data_ready_and_o !== 1'b1)
          $display("FAIL bp_beat%0d_ready: got %0b expected 1", c, dma_data_ready_and_o);
        else passed++;
      end
    end
    @(negedge clk);
    dma_data_v_i = 1'b0;
    #1;
    total++;
    if (dma_data_ready_and_o !== 1'b0)
      $display("FAIL bp_pop_after_8: got ready %0b expected 0", dma_data_ready_and_o);
    else passed++;
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    cache_dma_pkt_i   = {1'b0, 28'h500, 1'b1, 28'h600};
    cache_dma_pkt_v_i = 2'b10;
    dma_pkt_yumi_i    = 1'b1;
    @(negedge clk);
    cache_dma_pkt_v_i = 2'b01;
    #1;
    total++;
    if (cache_dma_pkt_yumi_o !== 2'b01)
      $display("FAIL rmw_wr_grant: got %b expected 01", cache_dma_pkt_yumi_o);
    else passed++;
    @(negedge clk);
    cache_dma_pkt_v_i  = 2'b00;
    dma_pkt_yumi_i     = 1'b0;
    cache_dma_data_v_i = 2'b01;
    cache_dma_data_i   = {64'h0, 64'h3000};
    dma_data_yumi_i    = 1'b1;
    #1;
    total++;
    if (dma_data_v_o !== 1'b1) $display("FAIL rmw_beat0_v: got %0b expected 1", dma_data_v_o);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    total++;
    if (dma_data_v_o !== 1'b0) $display("FAIL rmw_in_reset_v: got %0b expected 0", dma_data_v_o);
    else passed++;
    total++;
    if (cache_dma_data_yumi_o !== 2'b00)
      $display("FAIL rmw_in_reset_yumi: got %b expected 00", cache_dma_data_yumi_o);
    else passed++;
    @(negedge clk);
    reset_i                    = 1'b0;
    dma_data_yumi_i            = 1'b0;
    cache_dma_data_ready_and_i = 2'b11;
    #1;
    total++;
    if (dma_data_v_o !== 1'b0) $display("FAIL rmw_after_v: got %0b expected 0", dma_data_v_o);
    else passed++;
    total++;
    if (dma_data_ready_and_o !== 1'b0)
      $display("FAIL rmw_fifo_empty: got ready %0b expected 0", dma_data_ready_and_o);
    else passed++;
    total++;
    if (cache_dma_data_v_o !== 2'b00)
      $display("FAIL rmw_cache_v: got %b expected 00", cache_dma_data_v_o);
    else passed++;
    cache_dma_pkt_i   = {1'b0, 28'h0, 1'b0, 28'h700};
    cache_dma_pkt_v_i = 2'b01;
    #1;
    total++;
    if (dma_pkt_v_o !== 1'b1) $display("FAIL rmw_state_ready: got pkt_v %0b expected 1", dma_pkt_v_o);
    else passed++;
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    reset_i = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_lock();
    test_fifo_full();
    test_backpressure();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
